// File: rtl/topk_select.sv
// Iterative selection sort that emits the TOP_K largest words (and their original indices).
// Optional macro TOPK_MIN_MODE_EN adds mode_min to select the smallest words in ascending order.
module topk_select #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 16,
    parameter int TOP_K      = 10,
    parameter int ID_WIDTH   = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
`ifdef TOPK_MIN_MODE_EN
    input  logic                             mode_min,
`endif
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  array_in,
    output logic                             busy,
    output logic                             done,
    output logic                             out_valid,
    output logic [DATA_WIDTH*TOP_K-1:0]      array_out,
    output logic [ID_WIDTH*TOP_K-1:0]        id_out
);

    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST_POS  = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] FIRST_P   = IW'(NUM_WORDS - 2);
    localparam logic [IW-1:0] LAST_HEAD = IW'(TOP_K - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP, DONE} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] words [NUM_WORDS];
    logic [ID_WIDTH-1:0]   ids   [NUM_WORDS];
    logic [IW-1:0]         head, p, maxi;
    logic                  mode_q;
    logic                  take;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SCAN;
            SCAN: if (p == head) state_nx = SWAP;
            SWAP: state_nx = (head == LAST_HEAD) ? DONE : SCAN;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ties keep the lower position: the scan runs downward and moves max on equality.
    always_comb begin
        take = 1'b0;
        if (mode_q) take = (words[p] <= words[maxi]);
        else        take = (words[p] >= words[maxi]);
    end

`ifndef TOPK_MIN_MODE_EN
    assign mode_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                words[i] <= '0;
                ids[i]   <= ID_WIDTH'(i);
            end
            head      <= '0;
            p         <= FIRST_P;
            maxi      <= LAST_POS;
            out_valid <= 1'b0;
`ifdef TOPK_MIN_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                        words[i] <= array_in[i*DATA_WIDTH +: DATA_WIDTH];
                        ids[i]   <= ID_WIDTH'(i);
                    end
                    head      <= '0;
                    p         <= FIRST_P;
                    maxi      <= LAST_POS;
                    out_valid <= 1'b0;
`ifdef TOPK_MIN_MODE_EN
                    mode_q    <= mode_min;
`endif
                end
                SCAN: begin
                    if (take)      maxi <= p;
                    if (p != head) p    <= p - 1'b1;
                end
                SWAP: begin
                    words[head] <= words[maxi];
                    words[maxi] <= words[head];
                    ids[head]   <= ids[maxi];
                    ids[maxi]   <= ids[head];
                    if (head == LAST_HEAD) begin
                        out_valid <= 1'b1;
                    end else begin
                        head <= head + 1'b1;
                        p    <= FIRST_P;
                        maxi <= LAST_POS;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SCAN) || (state == SWAP);
    assign done = (state == DONE);

    always_comb begin
        array_out = '0;
        id_out    = '0;
        for (int unsigned r = 0; r < TOP_K; r++) begin
            array_out[r*DATA_WIDTH +: DATA_WIDTH] = words[r];
            id_out[r*ID_WIDTH +: ID_WIDTH]        = ids[r];
        end
    end

endmodule

// File: tb/tb_topk_select.sv
// Directed bench for topk_select (default build, descending selection) with a result scoreboard.
module tb_topk_select;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int K  = 10;
    localparam int IDW = 6;
    localparam int LAT = K*N - K*(K-1)/2;

    typedef struct {
        logic [DW*K-1:0]  arr;
        logic [IDW*K-1:0] ids;
    } res_t;

    logic             clk, rst, start;
    logic [DW*N-1:0]  array_in;
    logic             busy, done, out_valid;
    logic [DW*K-1:0]  array_out;
    logic [IDW*K-1:0] id_out;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    res_t sb[$];

    topk_select #(.DATA_WIDTH(DW), .NUM_WORDS(N), .TOP_K(K), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst(rst), .start(start), .array_in(array_in),
        .busy(busy), .done(done), .out_valid(out_valid),
        .array_out(array_out), .id_out(id_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [IDW*K-1:0] init_ids();
        logic [IDW*K-1:0] v = '0;
        for (int r = 0; r < K; r++) v[r*IDW +: IDW] = IDW'(r);
        return v;
    endfunction

    // Largest remaining word first; strict > keeps the lowest index on equal values.
    function automatic res_t model(input logic [DW*N-1:0] v);
        res_t res;
        bit   used[N];
        int   best;
        res.arr = '0;
        res.ids = '0;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int r = 0; r < K; r++) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (!used[i] && (best < 0 || v[i*DW +: DW] > v[best*DW +: DW])) best = i;
            res.arr[r*DW +: DW]  = v[best*DW +: DW];
            res.ids[r*IDW +: IDW] = IDW'(best);
            used[best] = 1'b1;
        end
        return res;
    endfunction

    task automatic launch(input logic [DW*N-1:0] v);
        array_in = v;
        start = 1'b1;
        sb.push_back(model(v));
        step();
        cyc = 0;
        start = 1'b0;
    endtask

    task automatic finish_sort(input string tag);
        bit   seen = 1'b0;
        res_t e;
        for (int c = 0; c < 400 && !seen; c++) begin
            step();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 256'(seen), 256'(1));
        if (seen) begin
            check({tag, "_latency"}, 256'(cyc), 256'(LAT));
            check({tag, "_out_valid"}, 256'(out_valid), 256'(1));
            if (sb.size() == 0) begin
                check({tag, "_sb_nonempty"}, 256'(0), 256'(1));
            end else begin
                e = sb.pop_front();
                check({tag, "_array_out"}, 256'(array_out), 256'(e.arr));
                check({tag, "_id_out"}, 256'(id_out), 256'(e.ids));
                for (int c = 0; c < 4; c++) step();
                check({tag, "_held_arr"}, 256'(array_out), 256'(e.arr));
                check({tag, "_held_id"}, 256'(id_out), 256'(e.ids));
                check({tag, "_held_valid"}, 256'(out_valid), 256'(1));
            end
        end
    endtask

    initial begin
        logic [DW*N-1:0] va, vb;
        bit              saw_done;

        rst = 1'b1; start = 1'b0; array_in = '0;
        step(); step();
        rst = 1'b0;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_array", 256'(array_out), 256'(0));
        check("rst_ids", 256'(id_out), 256'(init_ids()));

        // ascending ramp
        for (int i = 0; i < N; i++) va[i*DW +: DW] = DW'(i);
        launch(va);
        check("ramp_busy", 256'(busy), 256'(1));
        finish_sort("ramp");

        // all equal -> lower IDs win
        for (int i = 0; i < N; i++) va[i*DW +: DW] = 16'h0007;
        launch(va);
        finish_sort("ties");

        // high-bit words must rank above small ones (unsigned compare)
        for (int i = 0; i < N; i++) va[i*DW +: DW] = (i % 2 == 1) ? DW'(16'h8000 + i) : DW'(i);
        launch(va);
        finish_sort("unsigned");

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) va[i*DW +: DW] = DW'(($urandom & 32'hFFF0) | i);
            launch(va);
            finish_sort("random");
        end

        // start and new data mid-sort are ignored
        for (int i = 0; i < N; i++) va[i*DW +: DW] = DW'(16'h0100 + 3*i);
        for (int i = 0; i < N; i++) vb[i*DW +: DW] = DW'(16'hF000 - 7*i);
        launch(va);
        while (cyc < 20) step();
        array_in = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        check("midstart_busy", 256'(busy), 256'(1));
        finish_sort("midstart");
        launch(vb);
        finish_sort("after_done");

        // reset in the middle of a sort
        launch(va);
        while (cyc < 40) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_valid", 256'(out_valid), 256'(0));
        check("midrst_done", 256'(done), 256'(0));
        check("midrst_array", 256'(array_out), 256'(0));
        check("midrst_ids", 256'(id_out), 256'(init_ids()));
        saw_done = 1'b0;
        for (int c = 0; c < LAT + 20; c++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", 256'(saw_done), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
